// File: rtl/hub75_frame_buffer.sv
// rtl/hub75_frame_buffer.sv - double-banked 64x32 RGB frame buffer for a HUB75 scan driver
// Writes and clears go to the back bank; reads come from the front bank. Swaps happen at frame_done.
module hub75_frame_buffer (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [5:0] wr_x,
  input  logic [4:0] wr_y,
  input  logic [2:0] wr_rgb,
  input  logic       clr_req,
  input  logic       swap_req,
  input  logic       frame_done,
  input  logic       rd_en,
  input  logic [3:0] rd_row,
  input  logic [5:0] rd_col,
  output logic [5:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       swap_pending,
  output logic       front_sel
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic        front_q, front_d;
  logic        pend_q, pend_d;
  logic [5:0]  rd_data_q;
  logic        rd_valid_q;
  logic        swap_fire;

  logic        we_top, we_bot;
  logic [10:0] waddr;
  logic [2:0]  wdata;
  logic [10:0] raddr;

  // Bank index is the MSB of each array address: {bank, row[3:0], col[5:0]}.
  logic [2:0] top_mem [0:2047];
  logic [2:0] bot_mem [0:2047];

  assign busy      = (state_q == CLEAR);
  assign swap_fire = (pend_q | swap_req) & frame_done & ~busy;
  assign raddr     = {front_q, rd_row, rd_col};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_top  = 1'b0;
    we_bot  = 1'b0;
    waddr   = {~front_q, wr_y[3:0], wr_x};
    wdata   = wr_rgb;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
        end else if (wr_en) begin
          we_top = ~wr_y[4];
          we_bot = wr_y[4];
        end
      end
      CLEAR: begin
        we_top = 1'b1;
        we_bot = 1'b1;
        waddr  = {~front_q, cnt_q};
        wdata  = 3'b000;
        cnt_d  = cnt_q + 10'd1;
        if (cnt_q == 10'd1023) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    front_d = front_q;
    pend_d  = pend_q;
    if (swap_fire) begin
      front_d = ~front_q;
      pend_d  = 1'b0;
    end else if (swap_req) begin
      pend_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 10'd0;
      front_q    <= 1'b0;
      pend_q     <= 1'b0;
      rd_data_q  <= 6'd0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      front_q    <= front_d;
      pend_q     <= pend_d;
      rd_valid_q <= rd_en;
      if (rd_en) rd_data_q <= {top_mem[raddr], bot_mem[raddr]};
    end
  end

  // Memory is deliberately outside the reset domain; a reset mid-clear leaves it partly cleared.
  always_ff @(posedge clk) begin
    if (we_top) top_mem[waddr] <= wdata;
    if (we_bot) bot_mem[waddr] <= wdata;
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign swap_pending = pend_q;
  assign front_sel    = front_q;

endmodule

// File: tb/tb_hub75_frame_buffer.sv
// tb/tb_hub75_frame_buffer.sv - directed self-checking bench for hub75_frame_buffer
// Read expectations are queued when rd_en is driven and popped when rd_valid is due.
module tb_hub75_frame_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [5:0] wr_x = '0;
  logic [4:0] wr_y = '0;
  logic [2:0] wr_rgb = '0;
  logic       clr_req = 1'b0;
  logic       swap_req = 1'b0;
  logic       frame_done = 1'b0;
  logic       rd_en = 1'b0;
  logic [3:0] rd_row = '0;
  logic [5:0] rd_col = '0;
  logic [5:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       swap_pending;
  logic       front_sel;

  int checks = 0;
  int failures = 0;
  logic [5:0] exp_q[$];
  logic [5:0] last_data = 6'd0;

  always #5 clk = ~clk;

  hub75_frame_buffer dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_rgb(wr_rgb),
    .clr_req(clr_req), .swap_req(swap_req), .frame_done(frame_done),
    .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy), .swap_pending(swap_pending), .front_sel(front_sel)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; rd_valid/rd_data are checked against the scoreboard every cycle.
  task automatic tick();
    logic expv;
    expv = (exp_q.size() > 0);
    @(posedge clk);
    #1;
    chk("rd_valid", {31'd0, rd_valid}, {31'd0, expv});
    if (expv) last_data = exp_q.pop_front();
    chk("rd_data", {26'd0, rd_data}, {26'd0, last_data});
  endtask

  task automatic rd(input logic [3:0] row, input logic [5:0] col, input logic [5:0] exp);
    rd_en = 1'b1; rd_row = row; rd_col = col;
    exp_q.push_back(exp);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic wr(input logic [5:0] x, input logic [4:0] y, input logic [2:0] rgb);
    wr_en = 1'b1; wr_x = x; wr_y = y; wr_rgb = rgb;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic swap_now();
    swap_req = 1'b1; frame_done = 1'b1;
    tick();
    swap_req = 1'b0; frame_done = 1'b0;
  endtask

  task automatic run_clear(input string tag);
    int n;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    chk({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
    n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    chk({tag, "_busy_cycles"}, n, 32'd1024);
  endtask

  task automatic sweep_zero(input string tag);
    for (int a = 0; a < 1024; a++) begin
      rd(a[9:6], a[5:0], 6'b000000);
    end
    chk({tag, "_queue_drained"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    logic f0;
    int n;

    // reset values while rst is held
    #12;
    chk("rst_front_sel", {31'd0, front_sel}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_swap_pending", {31'd0, swap_pending}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_rd_data", {26'd0, rd_data}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // clear bank1, swap, clear bank0, then both banks read all zeros
    run_clear("clr1");
    swap_now();
    chk("swap1_front", {31'd0, front_sel}, 32'd1);
    chk("swap1_pending", {31'd0, swap_pending}, 32'd0);
    run_clear("clr0");
    sweep_zero("sweep_bank1");
    swap_now();
    chk("swap2_front", {31'd0, front_sel}, 32'd0);
    sweep_zero("sweep_bank0");

    // top/bottom write then swap_req followed later by frame_done
    wr(6'd5, 5'd3, 3'b101);
    wr(6'd5, 5'd19, 3'b011);
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    chk("pend_set", {31'd0, swap_pending}, 32'd1);
    chk("pend_front_hold", {31'd0, front_sel}, 32'd0);
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    chk("pend_repeat", {31'd0, swap_pending}, 32'd1);
    tick();
    chk("pend_stays", {31'd0, swap_pending}, 32'd1);
    frame_done = 1'b1; tick(); frame_done = 1'b0;
    chk("fd_swap_front", {31'd0, front_sel}, 32'd1);
    chk("fd_swap_pending", {31'd0, swap_pending}, 32'd0);
    frame_done = 1'b1; tick(); frame_done = 1'b0;
    chk("fd_no_pending", {31'd0, front_sel}, 32'd1);
    rd(4'd3, 6'd5, 6'b101011);
    tick();
    tick();

    // swap cycle with a write to back bank and a read of the old front bank
    wr_en = 1'b1; wr_x = 6'd0; wr_y = 5'd0; wr_rgb = 3'b110;
    rd_en = 1'b1; rd_row = 4'd3; rd_col = 6'd5; exp_q.push_back(6'b101011);
    swap_now();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("same_cycle_front", {31'd0, front_sel}, 32'd0);
    rd(4'd0, 6'd0, 6'b110000);
    rd(4'd3, 6'd5, 6'b000000);

    // clear bank1 with writes, a swap request, clr_req and frame_done inside it
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    n = 0;
    while (busy && n < 2000) begin
      swap_req   = (n == 50);
      clr_req    = (n == 60);
      frame_done = (n == 500);
      wr_en      = (n == 100 || n == 1000);
      wr_x = 6'd10; wr_y = 5'd10; wr_rgb = 3'b111;
      tick();
      if (n == 500) begin
        chk("busy_fd_front", {31'd0, front_sel}, 32'd0);
        chk("busy_fd_pending", {31'd0, swap_pending}, 32'd1);
      end
      n++;
    end
    swap_req = 1'b0; clr_req = 1'b0; frame_done = 1'b0; wr_en = 1'b0;
    chk("clr_busy_cycles", n, 32'd1024);
    chk("post_clr_pending", {31'd0, swap_pending}, 32'd1);
    chk("post_clr_front", {31'd0, front_sel}, 32'd0);
    frame_done = 1'b1; tick(); frame_done = 1'b0;
    chk("deferred_front", {31'd0, front_sel}, 32'd1);
    chk("deferred_pending", {31'd0, swap_pending}, 32'd0);
    rd(4'd10, 6'd10, 6'b000000);
    rd(4'd0, 6'd0, 6'b000000);

    // put visible data on the outputs, then reset in the middle of a clear
    wr(6'd0, 5'd0, 3'b111);
    swap_now();
    chk("pre_rst_front", {31'd0, front_sel}, 32'd0);
    rd(4'd0, 6'd0, 6'b111000);
    swap_now();
    f0 = front_sel;
    chk("pre_rst_front2", {31'd0, f0}, 32'd1);
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    rd_en = 1'b1; rd_row = 4'd0; rd_col = 6'd0;
    exp_q.push_back(6'b000000);
    tick();
    for (int i = 1; i < 300; i++) begin
      exp_q.push_back(6'b000000);
      tick();
    end
    rd_en = 1'b0;
    chk("mid_clr_busy", {31'd0, busy}, 32'd1);
    chk("mid_clr_pending", {31'd0, swap_pending}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_front", {31'd0, front_sel}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_pending", {31'd0, swap_pending}, 32'd0);
    chk("async_rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("async_rst_rd_data", {26'd0, rd_data}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_data = 6'd0;
    exp_q.delete();
    run_clear("clr_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
